// File: rtl/ncore_rst_seq_pkg.sv
// Shared types and helpers for the Ncore reset sequencer.
// State encoding and counter sizing live here so the top and the bench agree.
package ncore_rst_seq_pkg;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        RELEASE = 3'd1,
        RUN     = 3'd2,
        QUIESCE = 3'd3,
        ASSERT  = 3'd4
    } rst_state_e;

    function automatic int cnt_width(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ncore_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser, STAGES flops deep.
// o_rst_nxt is the value the output flop loads on the coming edge.
module ncore_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n,
    output logic o_rst_nxt
);

    logic [STAGES-1:0] r_stg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stg <= '0;
        end else begin
            r_stg <= {r_stg[STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_n   = r_stg[STAGES-1];
    assign o_rst_nxt = r_stg[STAGES-2];

endmodule

// File: rtl/ncore_rst_sequencer.sv
// Ncore reset sequencer: synchronised cold-boot release, staggered per-domain
// reset release, and software warm reset with a quiesce handshake.
module ncore_rst_sequencer
    import ncore_rst_seq_pkg::*;
#(
    parameter int NUM_DOM     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DLY   = 8,
    parameter int RST_HOLD    = 16,
    parameter int QUIESCE_TMO = 256
) (
    input  logic               clk_fr,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic [NUM_DOM-1:0] quiesce_ack,
    output logic [NUM_DOM-1:0] quiesce_req,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               rst_done,
    output logic               busy,
    output logic               tmo_err
);

    localparam int CW = cnt_width(STAGE_DLY, RST_HOLD, QUIESCE_TMO);
    localparam int IW = $clog2(NUM_DOM + 1);

    localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(QUIESCE_TMO - 1);
    localparam logic [IW-1:0] IDX_END   = IW'(NUM_DOM);

    rst_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [NUM_DOM-1:0] r_dom_rst_n;
    logic [NUM_DOM-1:0] r_qreq;
    logic              r_done;
    logic              r_busy;
    logic              r_tmo;

    logic              w_sync_rst_n;
    logic              w_sync_nxt;
    logic              w_sync_up;
    logic [NUM_DOM-1:0] w_rel_mask;

    ncore_rst_sync #(
        .STAGES    (SYNC_STAGES)
    ) u_sync (
        .i_clk     (clk_fr),
        .i_rst_n   (rst),
        .o_rst_n   (w_sync_rst_n),
        .o_rst_nxt (w_sync_nxt)
    );

    // Leave SYNC on the same edge the synchroniser output rises.
    assign w_sync_up = w_sync_nxt | w_sync_rst_n;

    always_comb begin
        w_rel_mask = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            if (r_idx == IW'(i)) w_rel_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            r_state     <= SYNC;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_qreq      <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_tmo       <= 1'b0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_sync_up) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                end
                RELEASE: begin
                    if (r_cnt == DLY_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == IDX_END) begin
                            r_state <= RUN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_dom_rst_n <= r_dom_rst_n | w_rel_mask;
                            r_idx       <= r_idx + IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        r_state <= QUIESCE;
                        r_cnt   <= '0;
                        r_qreq  <= '1;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                QUIESCE: begin
                    // Timeout still resets the domains; the error is only flagged.
                    if ((&quiesce_ack) || (r_cnt == TMO_LAST)) begin
                        if (!(&quiesce_ack)) r_tmo <= 1'b1;
                        r_state     <= ASSERT;
                        r_cnt       <= '0;
                        r_qreq      <= '0;
                        r_dom_rst_n <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ASSERT: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= SYNC;
                end
            endcase
        end
    end

    assign dom_rst_n   = r_dom_rst_n;
    assign quiesce_req = r_qreq;
    assign rst_done    = r_done;
    assign busy        = r_busy;
    assign tmo_err     = r_tmo;

endmodule

// File: tb/tb_ncore_rst_sequencer.sv
// Directed scoreboard bench for ncore_rst_sequencer: expectations are queued
// against edge numbers and popped as the sequencer reaches them.
module tb_ncore_rst_sequencer;

    logic       clk_fr = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] quiesce_ack = 4'h0;
    logic [3:0] quiesce_req;
    logic [3:0] dom_rst_n;
    logic       rst_done;
    logic       busy;
    logic       tmo_err;

    always #5 clk_fr = ~clk_fr;

    ncore_rst_sequencer #(
        .NUM_DOM     (4),
        .SYNC_STAGES (2),
        .STAGE_DLY   (8),
        .RST_HOLD    (16),
        .QUIESCE_TMO (256)
    ) dut (
        .clk_fr      (clk_fr),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .dom_rst_n   (dom_rst_n),
        .rst_done    (rst_done),
        .busy        (busy),
        .tmo_err     (tmo_err)
    );

    typedef struct {
        int         e;
        string      tag;
        logic [3:0] dom;
        logic [3:0] qreq;
        logic       done;
        logic       bsy;
        logic       tmo;
    } exp_t;

    exp_t q[$];
    int   cur = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic push(input int e, input string tag, input logic [3:0] dom,
                        input logic [3:0] qreq, input logic done,
                        input logic bsy, input logic tmo);
        exp_t x;
        x.e = e; x.tag = tag; x.dom = dom; x.qreq = qreq;
        x.done = done; x.bsy = bsy; x.tmo = tmo;
        q.push_back(x);
    endtask

    task automatic scan();
        exp_t x;
        while (q.size() > 0 && q[0].e <= cur) begin
            x = q.pop_front();
            n_chk++;
            assert (x.e == cur) else begin
                n_fail++;
                $error("FAIL %s missed: at edge %0d, required edge %0d", x.tag, cur, x.e);
            end
            n_chk++;
            assert (dom_rst_n === x.dom) else begin
                n_fail++;
                $error("FAIL %s dom_rst_n observed %b expected %b", x.tag, dom_rst_n, x.dom);
            end
            n_chk++;
            assert ({quiesce_req, rst_done, busy, tmo_err} ===
                    {x.qreq, x.done, x.bsy, x.tmo}) else begin
                n_fail++;
                $error("FAIL %s qreq/done/busy/tmo observed %b/%b/%b/%b expected %b/%b/%b/%b",
                       x.tag, quiesce_req, rst_done, busy, tmo_err,
                       x.qreq, x.done, x.bsy, x.tmo);
            end
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk_fr);
            cur++;
            #2;
            scan();
        end
    endtask

    task automatic now(input string tag, input logic [3:0] dom,
                       input logic [3:0] qreq, input logic done,
                       input logic bsy, input logic tmo);
        push(cur, tag, dom, qreq, done, bsy, tmo);
        scan();
    endtask

    task automatic pulse();
        sw_rst_req = 1'b1;
        @(posedge clk_fr);
        #2;
        sw_rst_req = 1'b0;
        cur = 0;
        scan();
    endtask

    // RELEASE entered at edge base+2; domains follow every 8 edges.
    task automatic relexp(input string p, input int base, input logic tmo);
        push(base + 1,  {p, "_pre"},  4'h0, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 9,  {p, "_d0lo"}, 4'h0, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 10, {p, "_d0"},   4'h1, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 17, {p, "_d1lo"}, 4'h1, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 18, {p, "_d1"},   4'h3, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 26, {p, "_d2"},   4'h7, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 33, {p, "_d3lo"}, 4'h7, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 34, {p, "_d3"},   4'hF, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 41, {p, "_nrun"}, 4'hF, 4'h0, 1'b0, 1'b1, tmo);
        push(base + 42, {p, "_run"},  4'hF, 4'h0, 1'b1, 1'b0, tmo);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk_fr);
        #2;
        now("por", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Cold boot
        rst = 1'b1;
        cur = 0;
        relexp("cold", 0, 1'b0);
        adv(45);

        // Warm reset with prompt ack
        push(0,  "wq_enter",  4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(5,  "wq_hold",   4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(6,  "wq_assert", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        push(21, "wq_held",   4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        relexp("warm", 20, 1'b0);
        pulse();
        adv(5);
        quiesce_ack = 4'hF;
        adv(1);
        quiesce_ack = 4'h0;
        adv(59);

        // Staggered acks, plus requests in QUIESCE and RELEASE that must be ignored
        push(0,   "gl_enter",  4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(20,  "gl_ignq",   4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(39,  "gl_pre",    4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(40,  "gl_assert", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        relexp("glitch", 54, 1'b0);
        push(110, "gl_once",   4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
        pulse();
        for (int k = 1; k < 40; k++) begin
            quiesce_ack = 4'hF ^ (4'b0001 << (k % 4));
            sw_rst_req = (k == 20);
            adv(1);
        end
        sw_rst_req = 1'b0;
        quiesce_ack = 4'hF;
        adv(1);
        quiesce_ack = 4'h0;
        adv(19);
        sw_rst_req = 1'b1;
        adv(1);
        sw_rst_req = 1'b0;
        adv(50);

        // Quiesce timeout
        quiesce_ack = 4'b0111;
        push(0,   "to_enter",  4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(255, "to_pre",    4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        push(256, "to_fire",   4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        relexp("tmo", 270, 1'b1);
        push(340, "to_sticky", 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
        pulse();
        adv(340);
        quiesce_ack = 4'h0;

        // Board reset clears tmo_err; then abort a release mid-sequence
        rst = 1'b0;
        #1;
        now("rst_clr", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        adv(2);
        now("rst_hold", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cur = 0;
        push(10, "mid_d0", 4'h1, 4'h0, 1'b0, 1'b1, 1'b0);
        push(18, "mid_d1", 4'h3, 4'h0, 1'b0, 1'b1, 1'b0);
        push(20, "mid_pre", 4'h3, 4'h0, 1'b0, 1'b1, 1'b0);
        adv(20);
        rst = 1'b0;
        #1;
        now("mid_abort", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        cur = 0;
        relexp("reboot", 0, 1'b0);
        adv(45);

        n_chk++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
